// File: rtl/ex_stage.sv
// EX stage of the 5-stage MIPS pipeline: ALU/address/link result, HI/LO with an
// iterative-latency mult/div unit, and the EX/MEM register. `EX_MADD_EN adds madd/maddu/msub/msubu.
module ex_stage #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC2,
    input  logic [31:0] Instr2,
    input  logic [31:0] A2,
    input  logic [31:0] B2,
    input  logic [31:0] imm32_2,
    input  logic [4:0]  WA2,
    output logic        Busy,
    output logic [31:0] PC3,
    output logic [31:0] Instr3,
    output logic [31:0] Result3,
    output logic [31:0] B3,
    output logic [4:0]  WA3,
    output logic [31:0] imm32_3
);

    localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [5:0]  w_op, w_fn;
    logic [4:0]  w_sh;
    logic        w_md_req, w_start, w_done, w_mthi, w_mtlo;
    logic [2:0]  w_md_sel;
    logic [31:0] w_res, w_quo, w_rem;
    logic [63:0] w_prod, w_hilo;

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_op;
    logic [31:0]   r_a, r_b, r_hi, r_lo;

    assign w_op   = Instr2[31:26];
    assign w_fn   = Instr2[5:0];
    assign w_sh   = Instr2[10:6];
    assign w_mthi = (w_op == 6'b000000) && (w_fn == 6'b010001);
    assign w_mtlo = (w_op == 6'b000000) && (w_fn == 6'b010011);

    // r_op encoding: [2:1] = mult/div/madd/msub, [0] = unsigned
    always_comb begin
        w_md_req = 1'b0;
        w_md_sel = 3'd0;
        if (w_op == 6'b000000) begin
            case (w_fn)
                6'b011000: begin w_md_req = 1'b1; w_md_sel = 3'd0; end
                6'b011001: begin w_md_req = 1'b1; w_md_sel = 3'd1; end
                6'b011010: begin w_md_req = 1'b1; w_md_sel = 3'd2; end
                6'b011011: begin w_md_req = 1'b1; w_md_sel = 3'd3; end
                default: ;
            endcase
        end
`ifdef EX_MADD_EN
        else if (w_op == 6'b011100) begin
            case (w_fn)
                6'b000000: begin w_md_req = 1'b1; w_md_sel = 3'd4; end
                6'b000001: begin w_md_req = 1'b1; w_md_sel = 3'd5; end
                6'b000100: begin w_md_req = 1'b1; w_md_sel = 3'd6; end
                6'b000101: begin w_md_req = 1'b1; w_md_sel = 3'd7; end
                default: ;
            endcase
        end
`endif
    end

    assign w_start = w_md_req && (r_cnt == '0);
    assign w_done  = (r_cnt == CW'(1));
    assign Busy    = w_start || (r_cnt != '0);

    assign w_hilo = {r_hi, r_lo};
    assign w_prod = r_op[0] ? ({32'b0, r_a} * {32'b0, r_b})
                            : ({{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b});

    always_comb begin
        w_quo = 32'd0;
        w_rem = 32'd0;
        if (r_b != 32'd0) begin
            if (r_op[0]) begin
                w_quo = r_a / r_b;
                w_rem = r_a % r_b;
            end else begin
                w_quo = $signed(r_a) / $signed(r_b);
                w_rem = $signed(r_a) % $signed(r_b);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_op  <= 3'd0;
            r_a   <= 32'd0;
            r_b   <= 32'd0;
            r_hi  <= 32'd0;
            r_lo  <= 32'd0;
        end else begin
            if (w_start) begin
                r_cnt <= (w_md_sel[2:1] == 2'b01) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                r_op  <= w_md_sel;
                r_a   <= A2;
                r_b   <= B2;
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_done) begin
                case (r_op[2:1])
                    2'b00: {r_hi, r_lo} <= w_prod;
                    2'b01: if (r_b != 32'd0) begin
                        r_lo <= w_quo;
                        r_hi <= w_rem;
                    end
`ifdef EX_MADD_EN
                    2'b10: {r_hi, r_lo} <= w_hilo + w_prod;
                    2'b11: {r_hi, r_lo} <= w_hilo - w_prod;
`endif
                    default: ;
                endcase
            end else if (r_cnt == '0) begin
                if (w_mthi) r_hi <= A2;
                if (w_mtlo) r_lo <= A2;
            end
        end
    end

    always_comb begin
        w_res = 32'd0;
        case (w_op)
            6'b000000: begin
                case (w_fn)
                    6'b000000: w_res = B2 << w_sh;
                    6'b000010: w_res = B2 >> w_sh;
                    6'b000011: w_res = $signed(B2) >>> w_sh;
                    6'b000100: w_res = B2 << A2[4:0];
                    6'b000110: w_res = B2 >> A2[4:0];
                    6'b000111: w_res = $signed(B2) >>> A2[4:0];
                    6'b001001: w_res = PC2 + 32'd8;
                    6'b010000: w_res = r_hi;
                    6'b010010: w_res = r_lo;
                    6'b100000, 6'b100001: w_res = A2 + B2;
                    6'b100010, 6'b100011: w_res = A2 - B2;
                    6'b100100: w_res = A2 & B2;
                    6'b100101: w_res = A2 | B2;
                    6'b100110: w_res = A2 ^ B2;
                    6'b100111: w_res = ~(A2 | B2);
                    6'b101010: w_res = {31'd0, $signed(A2) < $signed(B2)};
                    6'b101011: w_res = {31'd0, A2 < B2};
                    default: ;
                endcase
            end
            6'b000011: w_res = PC2 + 32'd8;
            6'b001000, 6'b001001: w_res = A2 + imm32_2;
            6'b001010: w_res = {31'd0, $signed(A2) < $signed(imm32_2)};
            6'b001011: w_res = {31'd0, A2 < imm32_2};
            6'b001100: w_res = A2 & {16'd0, imm32_2[15:0]};
            6'b001101: w_res = A2 | {16'd0, imm32_2[15:0]};
            6'b001110: w_res = A2 ^ {16'd0, imm32_2[15:0]};
            6'b001111: w_res = imm32_2 << 16;
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110,
            6'b101000, 6'b101001, 6'b101010, 6'b101011, 6'b101110:
                w_res = A2 + imm32_2;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            PC3     <= 32'd0;
            Instr3  <= 32'd0;
            Result3 <= 32'd0;
            B3      <= 32'd0;
            WA3     <= 5'd0;
            imm32_3 <= 32'd0;
        end else begin
            PC3     <= PC2;
            Instr3  <= Instr2;
            Result3 <= w_res;
            B3      <= B2;
            WA3     <= WA2;
            imm32_3 <= imm32_2;
        end
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage of the 5-stage MIPS pipeline. It sits between ID/EX and the memory stage.
- Computes ALU, address and link results.
- Owns HI/LO and a multi-cycle mult/div unit.
- Registers PC, Instr, Result, store data, write address and imm32 into the EX/MEM register that drives the memory stage.
- Raises Busy so the hazard unit can stall mult/div/HI/LO instructions in ID.

Parameters:
- MULT_CYCLES, 5, cycles from mult/multu issue until HI/LO are updated (>=1)
- DIV_CYCLES, 10, cycles from div/divu issue until HI/LO are updated (>=1)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high; clears all state
- PC2  in  32  PC of instruction in EX
- Instr2  in  32  instruction in EX; 0 = bubble (nop)
- A2  in  32  rs operand, already forwarded
- B2  in  32  rt operand, already forwarded
- imm32_2  in  32  extended immediate from ID
- WA2  in  5  destination register (0 = none)
- Busy  out  1  mult/div unit occupied; combinational
- PC3  out  32  EX/MEM registered PC
- Instr3  out  32  EX/MEM registered instruction
- Result3  out  32  EX/MEM registered ALU/address/link/HI/LO result
- B3  out  32  EX/MEM registered rt value (store data)
- WA3  out  5  EX/MEM registered destination
- imm32_3  out  32  EX/MEM registered immediate

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: PC3, Instr3, Result3, B3, WA3 and imm32_3 are 0. HI, LO and the counter are 0, so Busy is 0.
- EX/MEM register: captures every cycle; there is no stall input. The hazard unit inserts bubbles by driving Instr2 = 0.
- Result mux, one-cycle latency (all arithmetic mod 2^32, no overflow traps):
  - addu/add/addiu/addi: sum
  - subu/sub: difference
  - and, or, xor, nor
  - andi/ori/xori: zero-extended imm32_2
  - slt/slti: signed compare; sltu/sltiu: unsigned compare
  - sll/srl/sra: shamt = Instr2[10:6]; sllv/srlv/srav: shift amount = A2[4:0]
  - lui: imm32_2 << 16
  - loads/stores: A2 + imm32_2
  - jal/jalr: PC2 + 8
  - mfhi: HI; mflo: LO
  - anything else: 0
- Start: combinational; high when Instr2 is mult, multu, div or divu and the counter is 0.
  - On the Start edge the block latches the operands, the operation, and counter = MULT_CYCLES or DIV_CYCLES.
- Counter: decrements each cycle while nonzero. On the edge where it goes 1 -> 0, HI/LO are written:
  - mult/multu: {HI,LO} = signed/unsigned 64-bit product
  - div/divu: LO = quotient, HI = remainder; signed division truncates toward zero and the remainder takes the dividend's sign
- Divide by zero: counter still runs; HI/LO are left unchanged at completion.
- Busy = Start | (counter != 0).
  - Start at cycle t means HI/LO hold the new values from cycle t+N+1, and Busy is low at t+N+1.
  - An mfhi in EX at t+N+1 returns the new value.
- mthi/mtlo: HI or LO = A2 at the edge, only when the counter is 0.
- Defensive rules:
  - md-op or mthi/mtlo arriving while the counter is nonzero: HI/LO and the counter are unaffected; the instruction still passes to EX/MEM with Result3 = 0.
  - mfhi/mflo while busy: returns the current (old) HI/LO.
- Reset mid-operation aborts the operation: counter = 0, HI/LO = 0.

Optional Feature:
- Macro: EX_MADD_EN.
- Defined: decodes SPECIAL2 (opcode 011100) funct 000000 madd, 000001 maddu, 000100 msub, 000101 msubu.
  - Latency is MULT_CYCLES; Start and Busy rules are identical to mult.
  - On completion {HI,LO} = {HI,LO} ± product (signed or unsigned), using HI/LO values sampled at completion.
- Undefined: these encodings decode as unknown: Result3 = 0, with no HI/LO effect and no Busy.

Test Plan:
- Reset held 2 cycles mid-div (counter = 4) -> all outputs 0, Busy 0, HI = LO = 0 on the first cycle after release.
- addiu A2 = 0xFFFFFFFF, imm = 1 -> Result3 = 0x00000000 next cycle. sra B2 = 0x80000000 by 4 -> 0xF8000000. jal PC2 = 0x3000 -> Result3 = 0x3008.
- mult A2 = 0xFFFFFFFE, B2 = 3 at cycle t -> Busy high t..t+5. mfhi at t+6 gives 0xFFFFFFFF, mflo gives 0xFFFFFFFA. multu with the same operands -> HI = 0x00000002, LO = 0xFFFFFFFA.
- div A2 = -7 (0xFFFFFFF9), B2 = 2 -> after 11 cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. divu 7/0 -> HI/LO unchanged, Busy drops on schedule.
- Second mult issued while the counter = 3 -> first result committed unchanged, counter unaffected. mthi while busy ignored; mthi A2 = 0x1234 when idle -> mfhi next cycle = 0x1234.
- With EX_MADD_EN: HI:LO = 0x00000000_00000010, madd 2*3 -> LO = 0x16. Without EX_MADD_EN: same instruction -> Result3 = 0, Busy stays 0.
